// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: latches execute results, resolves branches, runs the
// handshaked data-memory access and produces the registered MEM/WB result.
module ex_mem_stage #(
    parameter int         TIMEOUT      = 16,
    parameter logic [2:0] BRANCH_ITYPE = 3'd3,
    parameter logic [2:0] JUMP_ITYPE   = 3'd4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        in_valid_i,
    input  logic [63:0] alu_result_i,
    input  logic [63:0] store_data_i,
    input  logic [63:0] branch_target_i,
    input  logic        zero_i,
    input  logic        ltz_i,
    input  logic [2:0]  funct3_i,
    input  logic [2:0]  i_type_i,
    input  logic [4:0]  rd_i,
    input  logic        regwrite_i,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic        memtoreg_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [63:0] dmem_wdata_o,
    output logic [7:0]  dmem_wstrb_o,
    input  logic        dmem_ready_i,
    input  logic [63:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        branch_taken_o,
    output logic [63:0] branch_target_o,
    output logic [4:0]  fwd_rd_o,
    output logic        fwd_regwrite_o,
    output logic [63:0] fwd_data_o,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic        wb_regwrite_o,
    output logic [63:0] wb_data_o,
    output logic        misalign_o,
    output logic        bus_error_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DROP} state_t;

    function automatic logic is_aligned(input logic [2:0] lane, input logic [1:0] sz);
        case (sz)
            2'd0:    return 1'b1;
            2'd1:    return ~lane[0];
            2'd2:    return lane[1:0] == 2'b00;
            default: return lane == 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] rdata,
                                                input logic [2:0]  lane,
                                                input logic [2:0]  f3);
        logic [63:0] sh;
        sh = rdata >> {lane, 3'b000};
        case (f3)
            3'b000:  return {{56{sh[7]}}, sh[7:0]};
            3'b001:  return {{48{sh[15]}}, sh[15:0]};
            3'b010:  return {{32{sh[31]}}, sh[31:0]};
            3'b100:  return {56'd0, sh[7:0]};
            3'b101:  return {48'd0, sh[15:0]};
            3'b110:  return {32'd0, sh[31:0]};
            default: return sh;
        endcase
    endfunction

    function automatic logic branch_cond(input logic [2:0] ityp, input logic [2:0] f3,
                                         input logic zero, input logic ltz);
        if (ityp == JUMP_ITYPE) return 1'b1;
        if (ityp != BRANCH_ITYPE) return 1'b0;
        case (f3)
            3'b000:         return zero;
            3'b001:         return ~zero;
            3'b100, 3'b110: return ltz;
            3'b101, 3'b111: return ~ltz;
            default:        return 1'b0;
        endcase
    endfunction

    logic             vld_p1, zero_p1, ltz_p1;
    logic             regwrite_p1, memread_p1, memwrite_p1, memtoreg_p1;
    logic [63:0]      alu_p1, sdata_p1, btgt_p1;
    logic [2:0]       f3_p1, ityp_p1;
    logic [4:0]       rd_p1;
    logic             vld_p2, regwrite_p2;
    logic [4:0]       rd_p2;
    logic [63:0]      data_p2;
    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             bus_error_q;

    logic [2:0]  lane;
    logic        mem_op, aligned, retire;
    logic [63:0] load_data;

    assign lane      = alu_p1[2:0];
    assign mem_op    = vld_p1 & (memread_p1 | memwrite_p1);
    assign aligned   = is_aligned(lane, f3_p1[1:0]);
    assign load_data = load_extend(dmem_rdata_i, lane, f3_p1);

    // A timed-out access sits in M for one extra cycle in S_DROP with the request withdrawn.
    assign dmem_req_o   = mem_op & aligned & (state != S_DROP);
    assign stall_o      = dmem_req_o & ~dmem_ready_i;
    assign misalign_o   = mem_op & ~aligned;
    assign retire       = vld_p1 & ~stall_o & ~misalign_o & (state != S_DROP);
    assign dmem_we_o    = memwrite_p1;
    assign dmem_addr_o  = {alu_p1[63:3], 3'b000};
    assign dmem_wdata_o = sdata_p1 << {lane, 3'b000};
    assign dmem_wstrb_o = size_mask(f3_p1[1:0]) << lane;

    assign branch_taken_o  = vld_p1 & branch_cond(ityp_p1, f3_p1, zero_p1, ltz_p1);
    assign branch_target_o = btgt_p1;

    assign fwd_rd_o       = rd_p1;
    assign fwd_regwrite_o = vld_p1 & regwrite_p1 & ~memread_p1;
    assign fwd_data_o     = alu_p1;

    assign wb_valid_o    = vld_p2;
    assign wb_rd_o       = rd_p2;
    assign wb_regwrite_o = vld_p2 & regwrite_p2;
    assign wb_data_o     = data_p2;
    assign bus_error_o   = bus_error_q;

    // EX -> M boundary
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_p1      <= 1'b0;
            alu_p1      <= '0;
            sdata_p1    <= '0;
            btgt_p1     <= '0;
            zero_p1     <= 1'b0;
            ltz_p1      <= 1'b0;
            f3_p1       <= '0;
            ityp_p1     <= '0;
            rd_p1       <= '0;
            regwrite_p1 <= 1'b0;
            memread_p1  <= 1'b0;
            memwrite_p1 <= 1'b0;
            memtoreg_p1 <= 1'b0;
        end else if (!stall_o) begin
            vld_p1      <= in_valid_i;
            alu_p1      <= alu_result_i;
            sdata_p1    <= store_data_i;
            btgt_p1     <= branch_target_i;
            zero_p1     <= zero_i;
            ltz_p1      <= ltz_i;
            f3_p1       <= funct3_i;
            ityp_p1     <= i_type_i;
            rd_p1       <= rd_i;
            regwrite_p1 <= regwrite_i;
            memread_p1  <= memread_i;
            memwrite_p1 <= memwrite_i;
            memtoreg_p1 <= memtoreg_i;
        end
    end

    // Memory access FSM with wait counter
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            bus_error_q <= 1'b0;
        end else begin
            bus_error_q <= 1'b0;
            case (state)
                S_IDLE, S_ACCESS: begin
                    if (stall_o) begin
                        if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                            state       <= S_DROP;
                            wait_cnt    <= '0;
                            bus_error_q <= 1'b1;
                        end else begin
                            state    <= S_ACCESS;
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        end
                    end else begin
                        state    <= S_IDLE;
                        wait_cnt <= '0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // M -> W boundary
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_p2      <= 1'b0;
            rd_p2       <= '0;
            regwrite_p2 <= 1'b0;
            data_p2     <= '0;
        end else begin
            vld_p2 <= retire;
            if (retire) begin
                rd_p2       <= rd_p1;
                regwrite_p2 <= regwrite_p1;
                data_p2     <= memtoreg_p1 ? load_data : alu_p1;
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: transaction-level model compared every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_ex_mem_stage;

    localparam int TIMEOUT = 16;

    logic        clk_i = 1'b0;
    logic        reset_i, in_valid_i;
    logic [63:0] alu_result_i, store_data_i, branch_target_i;
    logic        zero_i, ltz_i;
    logic [2:0]  funct3_i, i_type_i;
    logic [4:0]  rd_i;
    logic        regwrite_i, memread_i, memwrite_i, memtoreg_i;
    logic        dmem_req_o, dmem_we_o;
    logic [63:0] dmem_addr_o, dmem_wdata_o;
    logic [7:0]  dmem_wstrb_o;
    logic        dmem_ready_i;
    logic [63:0] dmem_rdata_i;
    logic        stall_o, branch_taken_o;
    logic [63:0] branch_target_o;
    logic [4:0]  fwd_rd_o;
    logic        fwd_regwrite_o;
    logic [63:0] fwd_data_o;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic        wb_regwrite_o;
    logic [63:0] wb_data_o;
    logic        misalign_o, bus_error_o;

    ex_mem_stage #(.TIMEOUT(TIMEOUT), .BRANCH_ITYPE(3'd3), .JUMP_ITYPE(3'd4)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .in_valid_i(in_valid_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i),
        .branch_target_i(branch_target_i), .zero_i(zero_i), .ltz_i(ltz_i),
        .funct3_i(funct3_i), .i_type_i(i_type_i), .rd_i(rd_i),
        .regwrite_i(regwrite_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
        .memtoreg_i(memtoreg_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_wstrb_o(dmem_wstrb_o), .dmem_ready_i(dmem_ready_i),
        .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o),
        .branch_taken_o(branch_taken_o), .branch_target_o(branch_target_o),
        .fwd_rd_o(fwd_rd_o), .fwd_regwrite_o(fwd_regwrite_o), .fwd_data_o(fwd_data_o),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_regwrite_o(wb_regwrite_o),
        .wb_data_o(wb_data_o), .misalign_o(misalign_o), .bus_error_o(bus_error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [63:0] alu, sdata, tgt, rdata;
        logic        zero, ltz;
        logic [2:0]  f3, ityp;
        logic [4:0]  rd;
        logic        rw, mr, mw, m2r;
        int          delay;   // wait cycles before ready, -1 = never
    } ins_t;

    int    n_chk = 0, n_fail = 0;
    bit    started = 0;
    ins_t  pres, m;
    logic  m_v = 1'b0;
    int    m_cyc = 0;
    logic  w_v = 1'b0, w_rw = 1'b0;
    logic [4:0]  w_rd = '0;
    logic [63:0] w_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model of the instruction in M ----------------
    function automatic int e_size();  return 1 << m.f3[1:0]; endfunction
    function automatic int e_lane();  return int'(m.alu % 64'd8); endfunction
    function automatic logic e_mem(); return m_v && (m.mr || m.mw); endfunction
    function automatic logic e_al();  return (e_lane() % e_size()) == 0; endfunction
    function automatic logic e_req(); return e_mem() && e_al() && m_cyc < TIMEOUT; endfunction
    function automatic logic e_stall(); return e_req() && m_cyc != m.delay; endfunction
    function automatic logic e_mis(); return e_mem() && !e_al(); endfunction
    function automatic logic e_berr(); return e_mem() && e_al() && m_cyc == TIMEOUT; endfunction

    function automatic logic [7:0] e_wstrb();
        logic [15:0] t;
        t = ((16'd1 << e_size()) - 16'd1) << e_lane();
        return t[7:0];
    endfunction

    function automatic logic [63:0] e_load();
        logic [63:0] v, mask;
        int sz;
        sz = e_size();
        v = m.rdata >> (8 * e_lane());
        if (sz < 8) begin
            mask = (64'd1 << (8 * sz)) - 64'd1;
            v = v & mask;
            if (!m.f3[2] && v[8*sz-1]) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic logic e_taken();
        if (!m_v) return 1'b0;
        if (m.ityp == 3'd4) return 1'b1;
        if (m.ityp != 3'd3) return 1'b0;
        case (m.f3)
            3'd0: return m.zero;
            3'd1: return !m.zero;
            3'd4, 3'd6: return m.ltz;
            3'd5, 3'd7: return !m.ltz;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_update();
        logic leave;
        if (reset_i) begin
            m_v = 0; m_cyc = 0; w_v = 0; w_rw = 0; w_rd = '0; w_data = '0;
        end else begin
            leave = !m_v || !e_stall();
            if (m_v && leave && !e_mis() && !e_berr()) begin
                w_v = 1; w_rd = m.rd; w_rw = m.rw;
                w_data = m.m2r ? e_load() : m.alu;
            end else begin
                w_v = 0;
            end
            if (leave) begin
                m_v = in_valid_i; m = pres; m_cyc = 0;
            end else begin
                m_cyc++;
            end
        end
    endtask

    task automatic drive_mem();
        dmem_ready_i = m_v && (m.mr || m.mw) && m_cyc == m.delay;
        dmem_rdata_i = m.rdata;
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_update();
        started = 1;
        #1;
        in_valid_i = 1'b0;
        drive_mem();
    endtask

    task automatic issue(input ins_t x);
        pres = x;
        alu_result_i = x.alu; store_data_i = x.sdata; branch_target_i = x.tgt;
        zero_i = x.zero; ltz_i = x.ltz; funct3_i = x.f3; i_type_i = x.ityp; rd_i = x.rd;
        regwrite_i = x.rw; memread_i = x.mr; memwrite_i = x.mw; memtoreg_i = x.m2r;
        in_valid_i = 1'b1;
        tick();
    endtask

    function automatic ins_t mk_alu(input logic [63:0] v, input logic [4:0] rd);
        ins_t x = '0;
        x.alu = v; x.rd = rd; x.rw = 1; x.ityp = 3'd1; x.delay = -1;
        return x;
    endfunction

    function automatic ins_t mk_ld(input logic [2:0] f3, input logic [63:0] a,
                                   input logic [63:0] rdata, input int dly, input logic [4:0] rd);
        ins_t x = '0;
        x.alu = a; x.f3 = f3; x.rdata = rdata; x.delay = dly; x.rd = rd;
        x.rw = 1; x.mr = 1; x.m2r = 1;
        return x;
    endfunction

    function automatic ins_t mk_st(input logic [2:0] f3, input logic [63:0] a,
                                   input logic [63:0] d, input int dly);
        ins_t x = '0;
        x.alu = a; x.f3 = f3; x.sdata = d; x.delay = dly; x.mw = 1;
        return x;
    endfunction

    function automatic ins_t mk_br(input logic [2:0] ityp, input logic [2:0] f3,
                                   input logic z, input logic l, input logic [63:0] t);
        ins_t x = '0;
        x.ityp = ityp; x.f3 = f3; x.zero = z; x.ltz = l; x.tgt = t; x.delay = -1;
        return x;
    endfunction

    // Wait (bounded) for the writeback of the instruction just issued, counting stalls.
    task automatic run_wb(input string name, output int stalls);
        bit seen = 0;
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (stall_o) stalls++;
            if (wb_valid_o) begin seen = 1; break; end
            tick();
        end
        chk({name, "_wb_seen"}, 64'(seen), 64'd1);
    endtask

    // ---------------- per-cycle compare process ----------------
    always @(negedge clk_i) begin
        if (started) begin
            chk("stall", 64'(stall_o), 64'(e_stall()));
            chk("dmem_req", 64'(dmem_req_o), 64'(e_req()));
            if (e_req()) begin
                chk("dmem_we", 64'(dmem_we_o), 64'(m.mw));
                chk("dmem_addr", dmem_addr_o, m.alu - (m.alu % 64'd8));
                chk("dmem_wstrb", 64'(dmem_wstrb_o), 64'(e_wstrb()));
                if (m.mw) chk("dmem_wdata", dmem_wdata_o, m.sdata << (8 * e_lane()));
            end
            chk("misalign", 64'(misalign_o), 64'(e_mis()));
            chk("bus_error", 64'(bus_error_o), 64'(e_berr()));
            chk("br_taken", 64'(branch_taken_o), 64'(e_taken()));
            if (e_taken()) chk("br_target", branch_target_o, m.tgt);
            chk("fwd_regwrite", 64'(fwd_regwrite_o), 64'(m_v && m.rw && !m.mr));
            if (m_v) begin
                chk("fwd_rd", 64'(fwd_rd_o), 64'(m.rd));
                chk("fwd_data", fwd_data_o, m.alu);
            end
            chk("wb_valid", 64'(wb_valid_o), 64'(w_v));
            chk("wb_regwrite", 64'(wb_regwrite_o), 64'(w_v && w_rw));
            if (w_v) begin
                chk("wb_rd", 64'(wb_rd_o), 64'(w_rd));
                chk("wb_data", wb_data_o, w_data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int stalls, berr;
        pres = '0; m = '0;
        reset_i = 1; in_valid_i = 0;
        alu_result_i = '0; store_data_i = '0; branch_target_i = '0;
        zero_i = 0; ltz_i = 0; funct3_i = '0; i_type_i = '0; rd_i = '0;
        regwrite_i = 0; memread_i = 0; memwrite_i = 0; memtoreg_i = 0;
        dmem_ready_i = 0; dmem_rdata_i = '0;

        tick(); tick();
        @(negedge clk_i);
        chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_req", 64'(dmem_req_o), 64'd0);
        chk("rst_wb_data", wb_data_o, 64'd0);
        reset_i = 0;
        tick();

        // ALU op: forward tap next cycle, writeback two cycles after input
        issue(mk_alu(64'h2A, 5'd5));
        @(negedge clk_i);
        chk("add_fwd_rd", 64'(fwd_rd_o), 64'd5);
        chk("add_fwd_data", fwd_data_o, 64'h2A);
        chk("add_fwd_rw", 64'(fwd_regwrite_o), 64'd1);
        tick();
        @(negedge clk_i);
        chk("add_wb_valid", 64'(wb_valid_o), 64'd1);
        chk("add_wb_data", wb_data_o, 64'h2A);
        tick();

        // Loads with wait states and sign/zero extension
        issue(mk_ld(3'b000, 64'h1003, 64'h00000000_80000000, 2, 5'd7));
        run_wb("lb", stalls);
        chk("lb_stalls", 64'(stalls), 64'd2);
        chk("lb_data", wb_data_o, 64'hFFFFFFFFFFFFFF80);
        issue(mk_ld(3'b100, 64'h1003, 64'h00000000_80000000, 2, 5'd7));
        run_wb("lbu", stalls);
        chk("lbu_data", wb_data_o, 64'h80);
        issue(mk_ld(3'b010, 64'h1004, 64'h80000001_00000000, 0, 5'd8));
        run_wb("lw", stalls);
        chk("lw_data", wb_data_o, 64'hFFFFFFFF80000001);
        issue(mk_ld(3'b110, 64'h1004, 64'h80000001_00000000, 1, 5'd8));
        run_wb("lwu", stalls);
        chk("lwu_data", wb_data_o, 64'h80000001);
        issue(mk_ld(3'b001, 64'h0006, 64'hF00D0000_00000000, 0, 5'd9));
        run_wb("lh", stalls);
        chk("lh_data", wb_data_o, 64'hFFFFFFFFFFFFF00D);
        issue(mk_ld(3'b011, 64'h0010, 64'h01234567_89ABCDEF, 3, 5'd12));
        run_wb("ld", stalls);
        chk("ld_stalls", 64'(stalls), 64'd3);
        chk("ld_data", wb_data_o, 64'h0123456789ABCDEF);

        // Stores: lane-shifted data and byte enables
        issue(mk_st(3'b001, 64'h2006, 64'hBEEF, 0));
        @(negedge clk_i);
        chk("sh_addr", dmem_addr_o, 64'h2000);
        chk("sh_wstrb", 64'(dmem_wstrb_o), 64'hC0);
        chk("sh_wdata", dmem_wdata_o, 64'hBEEF000000000000);
        chk("sh_we", 64'(dmem_we_o), 64'd1);
        tick();
        @(negedge clk_i);
        chk("sh_wb_regwrite", 64'(wb_regwrite_o), 64'd0);
        tick();
        issue(mk_st(3'b000, 64'h0005, 64'hAB, 1));
        @(negedge clk_i);
        chk("sb_wstrb", 64'(dmem_wstrb_o), 64'h20);
        chk("sb_wdata", dmem_wdata_o, 64'h0000AB0000000000);
        tick(); tick(); tick();
        issue(mk_st(3'b010, 64'h0004, 64'hCAFEF00D, 0));
        issue(mk_st(3'b011, 64'h0008, 64'h1122334455667788, 0));
        tick(); tick();

        // Branches and jumps
        issue(mk_br(3'd3, 3'b001, 1'b0, 1'b0, 64'h400));
        @(negedge clk_i);
        chk("bne_taken", 64'(branch_taken_o), 64'd1);
        chk("bne_target", branch_target_o, 64'h400);
        tick();
        @(negedge clk_i);
        chk("bne_one_cycle", 64'(branch_taken_o), 64'd0);
        issue(mk_br(3'd3, 3'b000, 1'b0, 1'b0, 64'h500));
        @(negedge clk_i);
        chk("beq_not_taken", 64'(branch_taken_o), 64'd0);
        issue(mk_br(3'd3, 3'b100, 1'b0, 1'b1, 64'h600));
        @(negedge clk_i);
        chk("blt_taken", 64'(branch_taken_o), 64'd1);
        issue(mk_br(3'd3, 3'b101, 1'b0, 1'b1, 64'h700));
        @(negedge clk_i);
        chk("bge_not_taken", 64'(branch_taken_o), 64'd0);
        issue(mk_br(3'd4, 3'b000, 1'b0, 1'b0, 64'h800));
        @(negedge clk_i);
        chk("jal_taken", 64'(branch_taken_o), 64'd1);
        chk("jal_target", branch_target_o, 64'h800);
        tick();

        // Back-to-back ALU ops
        issue(mk_alu(64'h11, 5'd1));
        issue(mk_alu(64'h22, 5'd2));
        issue(mk_alu(64'h33, 5'd3));
        tick(); tick();

        // Misaligned word load: dropped, no request, no stall
        issue(mk_ld(3'b010, 64'h1002, 64'hFFFF, -1, 5'd9));
        @(negedge clk_i);
        chk("lw_mis_pulse", 64'(misalign_o), 64'd1);
        chk("lw_mis_req", 64'(dmem_req_o), 64'd0);
        chk("lw_mis_stall", 64'(stall_o), 64'd0);
        tick();
        @(negedge clk_i);
        chk("lw_mis_no_wb", 64'(wb_valid_o), 64'd0);
        chk("lw_mis_one_cycle", 64'(misalign_o), 64'd0);
        tick();

        // Timeout: 16 stall cycles, bus error pulse, pipeline resumes
        issue(mk_ld(3'b011, 64'h3000, 64'h1234, -1, 5'd10));
        stalls = 0; berr = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (stall_o) stalls++;
            if (bus_error_o) berr++;
            if (!stall_o) break;
            tick();
        end
        chk("to_stalls", 64'(stalls), 64'd16);
        chk("to_bus_error", 64'(berr), 64'd1);
        tick();
        @(negedge clk_i);
        chk("to_no_wb", 64'(wb_valid_o), 64'd0);
        chk("to_pulse_end", 64'(bus_error_o), 64'd0);
        issue(mk_alu(64'h77, 5'd3));
        tick();
        @(negedge clk_i);
        chk("resume_wb", wb_data_o, 64'h77);

        // New input while stalled is ignored
        issue(mk_ld(3'b011, 64'h0018, 64'hABCD, 3, 5'd14));
        issue(mk_alu(64'h99, 5'd4));
        repeat (6) tick();

        // Reset in the middle of an access
        issue(mk_ld(3'b011, 64'h4000, 64'h0, -1, 5'd11));
        tick(); tick();
        reset_i = 1;
        tick();
        @(negedge clk_i);
        chk("rst_acc_req", 64'(dmem_req_o), 64'd0);
        chk("rst_acc_stall", 64'(stall_o), 64'd0);
        chk("rst_acc_wb", 64'(wb_valid_o), 64'd0);
        reset_i = 0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Sits directly downstream of the execute stage.
- Latches execute results into an EX/MEM register and resolves branches/jumps from the zero/less-than flags.
- Drives a handshaked data-memory port for loads/stores, aligning and extending load data.
- Produces the registered MEM/WB result and the forwarding taps consumed by the execute-stage forwarding unit.

Parameters:
- TIMEOUT, 16: max cycles a memory request may wait for dmem_ready_i before bus error.
- BRANCH_ITYPE, 3: i_type_i code marking conditional branch.
- JUMP_ITYPE, 4: i_type_i code marking unconditional jump.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  execute stage presents a valid instruction.
- alu_result_i  in  64  ALU result / memory address.
- store_data_i  in  64  forwarded rs2 value for stores.
- branch_target_i  in  64  PC+imm from branch adder.
- zero_i  in  1  ALU zero flag.
- ltz_i  in  1  ALU less-than flag.
- funct3_i  in  3  instruction funct3.
- i_type_i  in  3  instruction class code.
- rd_i  in  5  destination register.
- regwrite_i, memread_i, memwrite_i, memtoreg_i  in  1 each  control bits.
- dmem_req_o  out  1  memory request valid.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  64  doubleword-aligned address (alu[63:3],3'b0).
- dmem_wdata_o  out  64  store data, lane-shifted.
- dmem_wstrb_o  out  8  byte enables.
- dmem_ready_i  in  1  memory accepts/completes this cycle.
- dmem_rdata_i  in  64  read doubleword, valid with ready.
- stall_o  out  1  upstream must hold; in_valid_i ignored.
- branch_taken_o  out  1  redirect fetch and flush IF/ID/EX.
- branch_target_o  out  64  redirect PC.
- fwd_rd_o, fwd_regwrite_o, fwd_data_o  out  5/1/64  M-stage forwarding tap (ALU result).
- wb_valid_o, wb_rd_o, wb_regwrite_o, wb_data_o  out  1/5/1/64  registered writeback.
- misalign_o  out  1  pulse: misaligned access dropped.
- bus_error_o  out  1  pulse: timeout, access dropped.

Behaviour:
- Reset: all registers and outputs 0; FSM to IDLE; counter 0. Reset during an access drops dmem_req_o on the next cycle and discards the pending instruction.
- Capture: M register loads inputs when stall_o=0. Bubble (valid=0) when in_valid_i=0.
- Mem op in M:
  - Valid, memread|memwrite, aligned → FSM IDLE→ACCESS the same cycle. dmem_req_o=1 combinationally.
  - Address, we, wdata and wstrb stay stable until dmem_ready_i=1.
  - stall_o = ACCESS & !dmem_ready_i.
- Completion: ready=1 → W captures; FSM→IDLE; stall_o drops that cycle. Zero-wait memory gives 1-cycle M occupancy.
- Timeout: wait counter increments each ACCESS cycle without ready. At TIMEOUT, pulse bus_error_o, drop instruction (wb_valid_o=0 for it), return to IDLE.
- Sizes (funct3): 000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LD/SD, 100 LBU, 101 LHU, 110 LWU.
  - Lane = addr[2:0].
  - wstrb = size mask << lane; wdata = store_data << 8*lane.
  - Load = (rdata >> 8*lane) truncated, then sign- or zero-extended to 64.
- Misalignment (half addr[0]≠0; word addr[1:0]≠0; dword addr[2:0]≠0):
  - No request; misalign_o pulses 1 cycle; instruction dropped; no stall.
- Branches:
  - i_type=BRANCH_ITYPE: taken on 000 zero; 001 !zero; 100/110 ltz; 101/111 !ltz.
  - i_type=JUMP_ITYPE: always taken.
  - branch_taken_o is combinational from the valid M register, high exactly one cycle. branch_target_o = latched branch_target_i.
  - Branches never stall.
- Forwarding: fwd_regwrite_o = M valid & regwrite & !memread. fwd_data_o = ALU result.
- Writeback: W valid 1 cycle after M completes. wb_data_o = load data if memtoreg else ALU result. wb_regwrite_o forced 0 when W invalid.
- Stalled inputs: in_valid_i is ignored while stall_o=1; upstream must hold.

Test Plan:
- ADD result 0x2A, rd=5, regwrite, no mem → fwd tap rd 5 / 0x2A the next cycle; wb_valid_o=1, wb_data_o=0x2A two cycles after input.
- LB addr 0x1003, rdata 0x00000000_80000000 (byte3=0x80), ready after 2 wait cycles → stall_o high 2 cycles; wb_data_o=0xFFFFFFFFFFFFFF80. Same with LBU → 0x80.
- SH addr 0x2006, data 0xBEEF → dmem_addr_o=0x2000, wstrb=0xC0, wdata=0xBEEF<<48; dmem_we_o=1; wb_regwrite_o=0.
- BNE, zero_i=0, target 0x400 → branch_taken_o=1 for one cycle, branch_target_o=0x400. BEQ with zero_i=0 → not taken.
- LW addr 0x1002 → misalign_o pulse, dmem_req_o stays 0, no writeback. LD with ready never asserted → 16 stall cycles, bus_error_o pulse, pipeline resumes.
- Reset asserted during ACCESS → next cycle dmem_req_o=0, stall_o=0, wb_valid_o=0.
